// File: rtl/byte_lane_sizer_pkg.sv
// Shared definitions for the byte-lane sizer: 68040 SIZ codes, FSM states
// and the transfer-length helpers.
package byte_lane_sizer_pkg;

    typedef enum logic [1:0] {
        SIZ_LONG = 2'b00,
        SIZ_BYTE = 2'b01,
        SIZ_WORD = 2'b10,
        SIZ_LINE = 2'b11
    } siz_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WFETCH,
        ST_SETUP,
        ST_STROBE,
        ST_RECOVER,
        ST_BEAT,
        ST_ERR
    } state_e;

    function automatic logic [4:0] byte_count(input siz_e siz);
        case (siz)
            SIZ_BYTE: return 5'd1;
            SIZ_WORD: return 5'd2;
            SIZ_LONG: return 5'd4;
            default:  return 5'd16;
        endcase
    endfunction

    function automatic logic misaligned(input siz_e siz, input logic [1:0] addr_lo);
        case (siz)
            SIZ_BYTE: return 1'b0;
            SIZ_WORD: return addr_lo[0];
            default:  return (addr_lo != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/byte_strobe_timer.sv
// Down-counter that holds a device strobe for WAIT_CYCLES cycles; expire marks
// the final strobe cycle.
module byte_strobe_timer #(
    parameter int WAIT_CYCLES = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expire
);

    localparam logic [3:0] LOAD_VAL = 4'(WAIT_CYCLES - 1);

    logic [3:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= 4'd0;
        end else if (load) begin
            count_reg <= LOAD_VAL;
        end else if (en && (count_reg != 4'd0)) begin
            count_reg <= count_reg - 4'd1;
        end
    end

    assign expire = en && (count_reg == 4'd0);

endmodule

// File: rtl/byte_lane_sizer.sv
// Breaks byte/word/long/line transfers into byte accesses on an 8-bit
// peripheral bus and returns each assembled 32-bit beat upstream.
module byte_lane_sizer
    import byte_lane_sizer_pkg::*;
#(
    parameter int ADDR_W      = 24,
    parameter int WAIT_CYCLES = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_siz,
    input  logic              req_rw,
    input  logic [31:0]       req_wdata,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    output logic              rsp_valid,
    output logic [31:0]       rsp_data,
    output logic              rsp_last,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] dev_addr,
    output logic              dev_cs,
    output logic              dev_rd,
    output logic              dev_wr,
    output logic [7:0]        dev_wdata,
    input  logic [7:0]        dev_rdata
);

    state_e            state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg;
    siz_e              siz_reg;
    logic              rw_reg;
    logic [31:0]       wdata_reg;
    logic [31:0]       acc_reg;
    logic [31:0]       rsp_data_reg;
    logic [1:0]        byte_cnt_reg;
    logic [1:0]        long_cnt_reg;

    logic [4:0] total_bytes;
    logic [2:0] long_bytes;
    logic       last_byte;
    logic       last_long;
    logic [1:0] lane;
    logic [1:0] line_long;
    logic [4:0] lane_shift;
    logic       timer_load;
    logic       timer_en;
    logic       strobe_expire;

    assign total_bytes = byte_count(siz_reg);
    assign long_bytes  = (total_bytes > 5'd4) ? 3'd4 : total_bytes[2:0];
    assign last_byte   = ({1'b0, byte_cnt_reg} == (long_bytes - 3'd1));
    assign last_long   = !total_bytes[4] || (long_cnt_reg == 2'd3);

    // Big-endian lanes: offset k within the long lives at bit 8*(3-k).
    assign lane       = addr_reg[1:0] + byte_cnt_reg;
    assign line_long  = addr_reg[3:2] + long_cnt_reg;
    assign lane_shift = {~lane, 3'b000};

    assign timer_load = (state_reg == ST_SETUP);
    assign timer_en   = (state_reg == ST_STROBE);

    byte_strobe_timer #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_strobe_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (timer_load),
        .en    (timer_en),
        .expire(strobe_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (req_valid) begin
                    state_next = misaligned(siz_e'(req_siz), req_addr[1:0]) ? ST_ERR : ST_SETUP;
                end
            end
            ST_WFETCH:  if (wdata_valid) state_next = ST_SETUP;
            ST_SETUP:   state_next = ST_STROBE;
            ST_STROBE:  if (strobe_expire) state_next = ST_RECOVER;
            ST_RECOVER: state_next = last_byte ? ST_BEAT : ST_SETUP;
            ST_BEAT: begin
                if (last_long) begin
                    state_next = ST_IDLE;
                end else begin
                    state_next = rw_reg ? ST_SETUP : ST_WFETCH;
                end
            end
            default:    state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_reg     <= '0;
            siz_reg      <= SIZ_LONG;
            rw_reg       <= 1'b0;
            wdata_reg    <= 32'd0;
            acc_reg      <= 32'd0;
            rsp_data_reg <= 32'd0;
            byte_cnt_reg <= 2'd0;
            long_cnt_reg <= 2'd0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (req_valid) begin
                        addr_reg     <= req_addr;
                        siz_reg      <= siz_e'(req_siz);
                        rw_reg       <= req_rw;
                        wdata_reg    <= req_wdata;
                        acc_reg      <= 32'd0;
                        byte_cnt_reg <= 2'd0;
                        long_cnt_reg <= 2'd0;
                    end
                end
                ST_WFETCH: begin
                    if (wdata_valid) wdata_reg <= req_wdata;
                end
                ST_STROBE: begin
                    if (strobe_expire && rw_reg) acc_reg[lane_shift +: 8] <= dev_rdata;
                end
                ST_RECOVER: begin
                    if (last_byte) begin
                        byte_cnt_reg <= 2'd0;
                        rsp_data_reg <= rw_reg ? acc_reg : 32'd0;
                    end else begin
                        byte_cnt_reg <= byte_cnt_reg + 2'd1;
                    end
                end
                ST_BEAT: begin
                    if (!last_long) begin
                        long_cnt_reg <= long_cnt_reg + 2'd1;
                        acc_reg      <= 32'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready   = (state_reg == ST_IDLE);
    assign wdata_ready = (state_reg == ST_WFETCH);
    assign rsp_valid   = (state_reg == ST_BEAT) || (state_reg == ST_ERR);
    assign rsp_err     = (state_reg == ST_ERR);
    assign rsp_last    = (state_reg == ST_ERR) || ((state_reg == ST_BEAT) && last_long);
    assign rsp_data    = rsp_data_reg;

    // Line accesses wrap inside the 16-byte line; upper address bits are fixed.
    assign dev_addr  = {addr_reg[ADDR_W-1:4], line_long, lane};
    assign dev_cs    = (state_reg == ST_SETUP) || (state_reg == ST_STROBE);
    assign dev_rd    = (state_reg == ST_STROBE) && rw_reg;
    assign dev_wr    = (state_reg == ST_STROBE) && !rw_reg;
    assign dev_wdata = rw_reg ? 8'h00 : wdata_reg[lane_shift +: 8];

endmodule
